// File: rtl/dram_ctrl_gen_if.sv
// Bus bundle between the 68000 decode side and the FPM DRAM controller.
// With DRAM_REFOVF_EN defined it also carries the sticky RefOvf flag.
interface dram_ctrl_gen_if #(
  parameter int ROW_BITS = 11,
  parameter int COL_BITS = 10
);
  logic [ROW_BITS+COL_BITS:1] A;
  logic                       nAS;
  logic                       nWE;
  logic                       nLDS;
  logic                       nUDS;
  logic                       BACT;
  logic                       RAMCS;
  logic                       RAMReady;
  logic [ROW_BITS-1:0]        RA;
  logic                       nRAS;
  logic                       nCAS;
  logic                       nOE;
  logic                       nLWE;
  logic                       nUWE;
`ifdef DRAM_REFOVF_EN
  logic                       RefOvf;
`endif

  modport master (
    output A, nAS, nWE, nLDS, nUDS, BACT, RAMCS,
`ifdef DRAM_REFOVF_EN
    input  RefOvf,
`endif
    input  RAMReady, RA, nRAS, nCAS, nOE, nLWE, nUWE
  );

  modport slave (
    input  A, nAS, nWE, nLDS, nUDS, BACT, RAMCS,
`ifdef DRAM_REFOVF_EN
    output RefOvf,
`endif
    output RAMReady, RA, nRAS, nCAS, nOE, nLWE, nUWE
  );
endinterface

// File: rtl/dram_ctrl_gen.sv
// Parametrised FPM DRAM controller with built-in CAS-before-RAS refresh scheduling.
// Define DRAM_REFOVF_EN to add the sticky refresh-overflow flag RefOvf.
module dram_ctrl_gen #(
  parameter int ROW_BITS = 11,
  parameter int COL_BITS = 10,
  parameter int T_RCD    = 1,
  parameter int T_RP     = 2,
  parameter int T_RASR   = 2,
  parameter int REF_DIV  = 250,
  parameter int REF_MAX  = 4,
  parameter int REF_URG  = 2
) (
  input  logic           CLK,
  input  logic           nRES,
  dram_ctrl_gen_if.slave bus
);
  localparam int DIV_W = (REF_DIV > 1) ? $clog2(REF_DIV) : 1;
  localparam int BL_W  = $clog2(REF_MAX + 1);

  typedef enum logic [2:0] {IDLE, ROW, COL, PRE, REF_CAS, REF_RAS} state_t;

  state_t              state, stateNext;
  logic [2:0]          cnt, cntNext;
  logic [DIV_W-1:0]    divCnt, divNext;
  logic [BL_W-1:0]     backlog, backlogNext;
  logic                tick, refDec, urgent, ramReadyNext;
  logic                nRasNext, nCasNext, nOeNext, nLweNext, nUweNext;
  logic [ROW_BITS-1:0] raNext, rowAddr, colAddr;

  assign rowAddr = bus.A[ROW_BITS+COL_BITS:COL_BITS+1];
  assign colAddr = ROW_BITS'(bus.A[COL_BITS:1]);
  assign urgent  = (backlog >= BL_W'(REF_URG));
  assign tick    = (divCnt == DIV_W'(REF_DIV - 1));
  assign divNext = tick ? '0 : divCnt + DIV_W'(1);

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    refDec    = 1'b0;
    case (state)
      IDLE: begin
        if (urgent) begin
          stateNext = REF_CAS;
        end else if (bus.BACT && bus.RAMCS) begin
          stateNext = ROW;
          cntNext   = 3'(T_RCD - 1);
        end else if ((backlog != '0) && bus.BACT) begin
          stateNext = REF_CAS;
        end
      end
      ROW: begin
        if (bus.nAS) begin
          stateNext = PRE;
          cntNext   = 3'(T_RP - 1);
        end else if (cnt == 3'd0) begin
          stateNext = COL;
        end else begin
          cntNext = cnt - 3'd1;
        end
      end
      COL: begin
        if (bus.nAS) begin
          stateNext = PRE;
          cntNext   = 3'(T_RP - 1);
        end
      end
      PRE: begin
        if (cnt == 3'd0) stateNext = IDLE;
        else             cntNext   = cnt - 3'd1;
      end
      REF_CAS: begin
        stateNext = REF_RAS;
        cntNext   = 3'(T_RASR - 1);
        refDec    = 1'b1;
      end
      REF_RAS: begin
        if (cnt == 3'd0) begin
          stateNext = PRE;
          cntNext   = 3'(T_RP - 1);
        end else begin
          cntNext = cnt - 3'd1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Pin values are decoded from the next state so they register on the same edge.
  always_comb begin
    raNext   = bus.RA;
    nRasNext = 1'b1;
    nCasNext = 1'b1;
    nOeNext  = 1'b1;
    nLweNext = 1'b1;
    nUweNext = 1'b1;
    case (stateNext)
      ROW: begin
        nRasNext = 1'b0;
        raNext   = rowAddr;
      end
      COL: begin
        nRasNext = 1'b0;
        nCasNext = 1'b0;
        raNext   = colAddr;
        nOeNext  = ~bus.nWE;
        nLweNext = bus.nWE | bus.nLDS;
        nUweNext = bus.nWE | bus.nUDS;
      end
      REF_CAS: nCasNext = 1'b0;
      REF_RAS: begin
        nRasNext = 1'b0;
        nCasNext = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    backlogNext = backlog;
    if (tick && !refDec && (backlog != BL_W'(REF_MAX))) backlogNext = backlog + BL_W'(1);
    else if (!tick && refDec)                           backlogNext = backlog - BL_W'(1);
    ramReadyNext = !((backlogNext >= BL_W'(REF_URG)) ||
                     (stateNext == REF_CAS) || (stateNext == REF_RAS));
  end

  always_ff @(posedge CLK) begin
    if (!nRES) begin
      state        <= IDLE;
      cnt          <= 3'd0;
      divCnt       <= '0;
      backlog      <= '0;
      bus.RA       <= '0;
      bus.nRAS     <= 1'b1;
      bus.nCAS     <= 1'b1;
      bus.nOE      <= 1'b1;
      bus.nLWE     <= 1'b1;
      bus.nUWE     <= 1'b1;
      bus.RAMReady <= 1'b1;
    end else begin
      state        <= stateNext;
      cnt          <= cntNext;
      divCnt       <= divNext;
      backlog      <= backlogNext;
      bus.RA       <= raNext;
      bus.nRAS     <= nRasNext;
      bus.nCAS     <= nCasNext;
      bus.nOE      <= nOeNext;
      bus.nLWE     <= nLweNext;
      bus.nUWE     <= nUweNext;
      bus.RAMReady <= ramReadyNext;
    end
  end

`ifdef DRAM_REFOVF_EN
  // A tick that finds the backlog already full and nothing draining it is lost.
  always_ff @(posedge CLK) begin
    if (!nRES)                                                 bus.RefOvf <= 1'b0;
    else if (tick && !refDec && (backlog == BL_W'(REF_MAX)))   bus.RefOvf <= 1'b1;
  end
`endif
endmodule
